adder_pipe_nbit: RTL and testbench

Parametrised, pipelined N-bit add/subtract unit with valid/ready handshaking on both sides. It splits the carry chain into equal slices, one slice per pipeline stage, so wide additions close timing at full clock rate and accept one operation per cycle. It sits between an operand producer and a result consumer in datapaths wider than a single-cycle ripple adder can handle, and reports unsigned carry/borrow and signed overflow.

---
 rtl/adder_pipe_pkg.sv | 31 +++
 rtl/adder_nbit.sv | 24 ++
 rtl/adder_pipe_nbit.sv | 112 +++++++++++
 tb/tb_adder_pipe_nbit.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/adder_pipe_pkg.sv
// Shared types and constants for the pipelined add/subtract unit.
// Stage registers are sized for MAX_WIDTH. Each instance uses only its low WIDTH bits.
package adder_pipe_pkg;

    localparam int DEFAULT_WIDTH  = 16;
    localparam int DEFAULT_STAGES = 4;
    localparam int MAX_WIDTH      = 64;

    typedef struct packed {
        logic                 valid;
        logic [MAX_WIDTH-1:0] psum;
        logic                 carry;
        logic [MAX_WIDTH-1:0] a_rem;
        logic [MAX_WIDTH-1:0] b_rem;
        logic                 a_msb;
        logic                 b_msb;
    } stage_t;

    // Most negative two's-complement value of width w: 1000...0
    function automatic logic [MAX_WIDTH-1:0] sat_min(input int w);
        logic [MAX_WIDTH-1:0] one;
        one = {{(MAX_WIDTH-1){1'b0}}, 1'b1};
        return one << (w - 1);
    endfunction

    // Most positive two's-complement value of width w: 0111...1
    function automatic logic [MAX_WIDTH-1:0] sat_max(input int w);
        return sat_min(w) - {{(MAX_WIDTH-1){1'b0}}, 1'b1};
    endfunction

endpackage

// File: rtl/adder_nbit.sv
// Ripple-carry adder of parametrised width.
// The overflow port is the raw carry out of the MSB.
module adder_nbit #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
    output logic [WIDTH-1:0] sum,
    output logic             overflow
);

    logic [WIDTH:0] c;

    assign c[0] = carry_in;

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
        assign sum[gi]  = a[gi] ^ b[gi] ^ c[gi];
        assign c[gi+1]  = (a[gi] & b[gi]) | (c[gi] & (a[gi] ^ b[gi]));
    end

    assign overflow = c[WIDTH];

endmodule

// File: rtl/adder_pipe_nbit.sv
// Pipelined N-bit add/subtract unit. Each stage resolves one slice of the carry chain.
// Optional macro ADDER_PIPE_SAT_EN saturates sum on signed overflow.
module adder_pipe_nbit
    import adder_pipe_pkg::*;
#(
    parameter int WIDTH  = DEFAULT_WIDTH,
    parameter int STAGES = DEFAULT_STAGES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             overflow
);

    localparam int SLICE = WIDTH / ((STAGES < 1) ? 1 : STAGES);

    if (STAGES < 1 || (WIDTH % ((STAGES < 1) ? 1 : STAGES)) != 0 || WIDTH > MAX_WIDTH)
    begin : g_param_check
        $error("adder_pipe_nbit: WIDTH must be a multiple of STAGES, STAGES >= 1, WIDTH <= MAX_WIDTH");
    end

    logic   advance;
    stage_t in_stage;
    stage_t last_q;
    logic   ovf;
    logic   unused_bits;

    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;

    // Subtraction is A + ~B + 1, so carry_in is ignored in sub mode
    always_comb begin
        in_stage                   = '0;
        in_stage.valid             = in_valid;
        in_stage.a_rem[WIDTH-1:0]  = a;
        in_stage.b_rem[WIDTH-1:0]  = sub ? ~b : b;
        in_stage.carry             = sub ? 1'b1 : carry_in;
        in_stage.a_msb             = a[WIDTH-1];
        in_stage.b_msb             = sub ? ~b[WIDTH-1] : b[WIDTH-1];
    end

    for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
        stage_t            stage_src;
        stage_t            stage_d;
        stage_t            stage_q;
        logic [SLICE-1:0]  slice_sum;
        logic              slice_carry;

        if (gi == 0) begin : g_first
            assign stage_src = in_stage;
        end else begin : g_next
            assign stage_src = g_stage[gi-1].stage_q;
        end

        adder_nbit #(.WIDTH(SLICE)) u_adder (
            .a        (stage_src.a_rem[gi*SLICE +: SLICE]),
            .b        (stage_src.b_rem[gi*SLICE +: SLICE]),
            .carry_in (stage_src.carry),
            .sum      (slice_sum),
            .overflow (slice_carry)
        );

        always_comb begin
            stage_d                          = stage_src;
            stage_d.psum[gi*SLICE +: SLICE]  = slice_sum;
            stage_d.carry                    = slice_carry;
            stage_d.a_rem[gi*SLICE +: SLICE] = '0;
            stage_d.b_rem[gi*SLICE +: SLICE] = '0;
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                stage_q <= '0;
            end else if (advance) begin
                stage_q <= stage_d;
            end
        end
    end

    assign last_q    = g_stage[STAGES-1].stage_q;
    assign out_valid = last_q.valid;
    assign carry_out = last_q.carry;
    assign ovf       = (last_q.a_msb == last_q.b_msb) && (last_q.psum[WIDTH-1] != last_q.a_msb);
    assign overflow  = ovf;

`ifdef ADDER_PIPE_SAT_EN
    localparam logic [MAX_WIDTH-1:0] SAT_MAX_FULL = sat_max(WIDTH);
    localparam logic [MAX_WIDTH-1:0] SAT_MIN_FULL = sat_min(WIDTH);

    always_comb begin
        sum = last_q.psum[WIDTH-1:0];
        if (ovf) begin
            sum = last_q.a_msb ? SAT_MIN_FULL[WIDTH-1:0] : SAT_MAX_FULL[WIDTH-1:0];
        end
    end
`else
    assign sum = last_q.psum[WIDTH-1:0];
`endif

    // Consumed operand bits and bits above WIDTH are always zero
    assign unused_bits = ^{last_q.psum, last_q.a_rem, last_q.b_rem};

endmodule

// File: tb/tb_adder_pipe_nbit.sv
// Directed self-checking bench for adder_pipe_nbit (WIDTH=16, STAGES=4).
// Expectations for overflow cases follow ADDER_PIPE_SAT_EN when defined.
module tb_adder_pipe_nbit;

    localparam int WIDTH  = 16;
    localparam int STAGES = 4;
`ifdef ADDER_PIPE_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             carry_in;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             carry_out;
    logic             overflow;

    int checks = 0;
    int errors = 0;

    adder_pipe_nbit #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .carry_in  (carry_in),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .carry_out (carry_out),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stream vectors: a, b, carry_in, sub -> sum, carry_out, overflow
    logic [15:0] sa   [8] = '{16'h0001, 16'h1000, 16'hFFFF, 16'h1234, 16'h0F0F, 16'h4000, 16'h0000, 16'hABCD};
    logic [15:0] sb   [8] = '{16'h0002, 16'h2000, 16'hFFFF, 16'h0234, 16'h00F1, 16'h4000, 16'h0001, 16'h1111};
    logic        scin [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    logic        ssub [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [15:0] es   [8] = '{16'h0003, 16'h3000, 16'hFFFE, 16'h1000, 16'h1001,
                              (SAT ? 16'h7FFF : 16'h8000), 16'hFFFF, 16'hBCDE};
    logic        ec   [8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic        eo   [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One operation through an empty pipe; checks exact latency and the result
    task automatic run_single(input string tag, input logic [15:0] ta, input logic [15:0] tb_op,
                              input logic tcin, input logic tsub,
                              input logic [15:0] xs, input logic xc, input logic xo);
        @(negedge clk);
        in_valid  = 1'b1;
        a         = ta;
        b         = tb_op;
        carry_in  = tcin;
        sub       = tsub;
        out_ready = 1'b1;
        #1;
        check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        for (int i = 0; i < STAGES - 1; i++) begin
            @(negedge clk);
            check({tag, "_early_valid"}, 32'(out_valid), 32'd0);
            @(posedge clk);
        end
        @(negedge clk);
        #1;
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_sum"}, 32'(sum), 32'(xs));
        check({tag, "_carry"}, 32'(carry_out), 32'(xc));
        check({tag, "_ovf"}, 32'(overflow), 32'(xo));
        $display("txn %s: a=0x%04h b=0x%04h cin=%0d sub=%0d -> sum=0x%04h c=%0d v=%0d",
                 tag, ta, tb_op, tcin, tsub, sum, carry_out, overflow);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int          c;
        int          sent;
        int          rcv;
        bit          hold;
        logic [15:0] hsum;
        logic        hc;
        logic        ho;

        rst       = 1'b1;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        carry_in  = 1'b0;
        sub       = 1'b0;
        out_ready = 1'b1;

        // Reset then idle
        @(posedge clk);
        @(posedge clk);
        #1;
        check("rst_in_ready_during", 32'(in_ready), 32'd1);
        check("rst_out_valid_during", 32'(out_valid), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_sum", 32'(sum), 32'd0);
        check("rst_carry", 32'(carry_out), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        $display("txn reset: out_valid=%0d in_ready=%0d sum=0x%04h", out_valid, in_ready, sum);

        // Directed single operations
        run_single("add_cin",     16'h00FF, 16'h0001, 1'b1, 1'b0, 16'h0101, 1'b0, 1'b0);
        run_single("carry_all",   16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        run_single("sub_ovf",     16'h8000, 16'h0001, 1'b0, 1'b1,
                   (SAT ? 16'h8000 : 16'h7FFF), 1'b1, 1'b1);
        run_single("add_pos_ovf", 16'h7FFF, 16'h0001, 1'b0, 1'b0,
                   (SAT ? 16'h7FFF : 16'h8000), 1'b0, 1'b1);
        run_single("sub_noborrow", 16'h0005, 16'h0003, 1'b0, 1'b1, 16'h0002, 1'b1, 1'b0);
        run_single("sub_borrow_cin", 16'h0003, 16'h0005, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);

        // Back-to-back stream with out_ready low in cycles 5..9
        c    = 0;
        sent = 0;
        rcv  = 0;
        hold = 1'b0;
        hsum = '0;
        hc   = 1'b0;
        ho   = 1'b0;
        while (rcv < 8 && c < 60) begin
            @(negedge clk);
            out_ready = !(c >= 5 && c <= 9);
            in_valid  = (sent < 8);
            if (sent < 8) begin
                a        = sa[sent];
                b        = sb[sent];
                carry_in = scin[sent];
                sub      = ssub[sent];
            end
            #1;
            if (hold) begin
                check("hold_valid", 32'(out_valid), 32'd1);
                check("hold_sum", 32'(sum), 32'(hsum));
                check("hold_carry", 32'(carry_out), 32'(hc));
                check("hold_ovf", 32'(overflow), 32'(ho));
            end
            hold = out_valid && !out_ready;
            if (hold) begin
                hsum = sum;
                hc   = carry_out;
                ho   = overflow;
                check("stall_in_ready", 32'(in_ready), 32'd0);
            end
            if (out_valid && out_ready) begin
                check($sformatf("stream%0d_sum", rcv), 32'(sum), 32'(es[rcv]));
                check($sformatf("stream%0d_carry", rcv), 32'(carry_out), 32'(ec[rcv]));
                check($sformatf("stream%0d_ovf", rcv), 32'(overflow), 32'(eo[rcv]));
                $display("txn stream%0d: cycle=%0d sum=0x%04h c=%0d v=%0d",
                         rcv, c, sum, carry_out, overflow);
                rcv++;
            end
            if (in_valid && in_ready) sent++;
            @(posedge clk);
            c++;
        end
        check("stream_count", 32'(rcv), 32'd8);
        check("stream_sent", 32'(sent), 32'd8);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("stream_no_dup", 32'(out_valid), 32'd0);
        end

        // Reset with three operations in flight
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            a        = 16'h0100 + 16'(i);
            b        = 16'h0010;
            carry_in = 1'b0;
            sub      = 1'b0;
            @(posedge clk);
        end
        @(negedge clk);
        in_valid = 1'b0;
        rst      = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("flush_out_valid", 32'(out_valid), 32'd0);
        end
        $display("txn mid_reset: in-flight operations discarded");
        run_single("post_rst", 16'h1234, 16'h1111, 1'b0, 1'b0, 16'h2345, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
